// File: rtl/router_pkt_tx.sv
// router_pkt_tx: packet source for the 1x3 router input port.
// It accepts a command (destination, length), buffers the whole payload and then
// streams header, payload and parity to the router, honouring its busy back-pressure.
// Ports:
//   clock_i, reset_i      clock and synchronous active-high reset
//   cmd_valid_i/_ready_o  command handshake; cmd_addr_i, cmd_len_i, cmd_corrupt_i
//   cmd_err_o             1-cycle pulse when a command is rejected
//   pay_valid_i/_ready_o  payload byte handshake; pay_data_i
//   busy_i                router busy; the presented byte is held while high
//   pkt_valid_o           high for header and payload, low for the parity byte
//   pkt_data_o            byte presented to the router
//   tx_done_o             1-cycle pulse once the parity byte has been accepted
module router_pkt_tx #(
  parameter int unsigned MaxLen    = 63,
  parameter int unsigned GapCycles = 2
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_addr_i,
  input  logic [5:0] cmd_len_i,
  input  logic       cmd_corrupt_i,
  output logic       cmd_err_o,
  input  logic       pay_valid_i,
  output logic       pay_ready_o,
  input  logic [7:0] pay_data_i,
  input  logic       busy_i,
  output logic       pkt_valid_o,
  output logic [7:0] pkt_data_o,
  output logic       tx_done_o
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StHeader,
    StPayload,
    StParity,
    StGap
  } state_e;

  state_e     state_q;
  logic [1:0] addr_q;
  logic [5:0] len_q;
  logic       corrupt_q;
  logic [7:0] parity_q;
  logic [5:0] wr_idx_q;
  logic [5:0] rd_idx_q;
  logic [7:0] gap_cnt_q;
  logic [7:0] buf_q [MaxLen];
  logic       pkt_valid_q;
  logic [7:0] pkt_data_q;
  logic       cmd_err_q;
  logic       tx_done_q;

  logic       cmd_bad;
  logic [7:0] header;

  assign cmd_bad = (cmd_addr_i == 2'd3) || (cmd_len_i == 6'd0) || (32'(cmd_len_i) > MaxLen);
  assign header  = {len_q, addr_q};

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      addr_q      <= 2'd0;
      len_q       <= 6'd0;
      corrupt_q   <= 1'b0;
      parity_q    <= 8'h00;
      wr_idx_q    <= 6'd0;
      rd_idx_q    <= 6'd0;
      gap_cnt_q   <= 8'd0;
      pkt_valid_q <= 1'b0;
      pkt_data_q  <= 8'h00;
      cmd_err_q   <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      cmd_err_q <= 1'b0;
      tx_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid_i) begin
            if (cmd_bad) begin
              cmd_err_q <= 1'b1;
            end else begin
              addr_q    <= cmd_addr_i;
              len_q     <= cmd_len_i;
              corrupt_q <= cmd_corrupt_i;
              parity_q  <= {cmd_len_i, cmd_addr_i};
              wr_idx_q  <= 6'd0;
              state_q   <= StLoad;
            end
          end
        end
        StLoad: begin
          if (pay_valid_i) begin
            buf_q[wr_idx_q] <= pay_data_i;
            parity_q        <= parity_q ^ pay_data_i;
            wr_idx_q        <= wr_idx_q + 6'd1;
            if (wr_idx_q == len_q - 6'd1) begin
              pkt_valid_q <= 1'b1;
              pkt_data_q  <= header;
              state_q     <= StHeader;
            end
          end
        end
        StHeader: begin
          if (!busy_i) begin
            pkt_data_q <= buf_q[0];
            rd_idx_q   <= 6'd1;
            state_q    <= StPayload;
          end
        end
        StPayload: begin
          if (!busy_i) begin
            // rd_idx_q == len_q means buf[len-1] is the byte just accepted.
            if (rd_idx_q == len_q) begin
              pkt_valid_q <= 1'b0;
              pkt_data_q  <= parity_q ^ {7'b0, corrupt_q};
              state_q     <= StParity;
            end else begin
              pkt_data_q <= buf_q[rd_idx_q];
              rd_idx_q   <= rd_idx_q + 6'd1;
            end
          end
        end
        StParity: begin
          if (!busy_i) begin
            tx_done_q  <= 1'b1;
            pkt_data_q <= 8'h00;
            gap_cnt_q  <= 8'd0;
            state_q    <= StGap;
          end
        end
        StGap: begin
          if (gap_cnt_q == 8'(GapCycles - 1)) begin
            state_q <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready_o = (state_q == StIdle);
  assign pay_ready_o = (state_q == StLoad);
  assign cmd_err_o   = cmd_err_q;
  assign pkt_valid_o = pkt_valid_q;
  assign pkt_data_o  = pkt_data_q;
  assign tx_done_o   = tx_done_q;

endmodule
